pin_cmd_responder: RTL and testbench

Chip-side responder for the host byte protocol used by the bench and the board host to drive `tt_um_idann` over its TinyTapeout pins. It accepts one byte per four-phase strobe/ack handshake on `ui_in`/`uio_in[0]`, decodes write/read/clear commands, and maintains a small register file that feeds the network core. Read results and status are returned on `uo_out`.

---
 rtl/pin_cmd_responder.sv | 78 +++++++
 tb/tb_pin_cmd_responder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pin_cmd_responder.sv
// pin_cmd_responder: strobe/ack byte responder with write/read/clear register file
module pin_cmd_responder #(
  parameter int NREGS = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [7:0]         ui_in,
  input  logic [7:0]         uio_in,
  output logic [7:0]         uo_out,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe,
  output logic [NREGS*8-1:0] regs_flat
);
  typedef enum logic {H_IDLE, H_ACK} hs_t;
  typedef enum logic {C_OP, C_WDATA} cmd_t;
  localparam logic [4:0] NR = 5'(NREGS);
  hs_t hs_state, hs_next;
  cmd_t cmd_state, cmd_next;
  logic [SYNC_STAGES-1:0] sync;
  logic strb_s, ack, err, cap, lo_ok, is_wr, is_rd, is_clr, op_ok, unused_uio;
  logic [3:0] lo, wr_idx;
  logic [7:0] rd_data;
  assign strb_s = sync[SYNC_STAGES-1];
  assign lo = ui_in[3:0];
  assign lo_ok = {1'b0, lo} < NR;
  assign is_wr = ui_in[7:4] == 4'h1 && lo_ok;
  assign is_rd = ui_in[7:4] == 4'h2 && lo_ok;
  assign is_clr = ui_in == 8'h30;
  assign op_ok = is_wr | is_rd | is_clr;
  assign unused_uio = ^uio_in[7:1];
  // Strobe synchronizer; ui_in is held stable by the host so only strb needs it
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], uio_in[0]};
  // State registers for both FSMs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hs_state <= H_IDLE;
      cmd_state <= C_OP;
    end else begin
      hs_state <= hs_next;
      cmd_state <= cmd_next;
    end
  // Next-state logic: a held strobe parks in H_ACK; command FSM moves only on capture
  always_comb begin
    hs_next = hs_state == H_IDLE ? ((strb_s && ena) ? H_ACK : H_IDLE) : (strb_s ? H_ACK : H_IDLE);
    cmd_next = !cap ? cmd_state : cmd_state == C_WDATA ? C_OP : is_wr ? C_WDATA : C_OP;
  end
  // Handshake outputs, capture pulse and register read mux
  always_comb begin
    cap = hs_state == H_IDLE && strb_s && ena;
    ack = hs_state == H_ACK;
    uio_out = {5'b0, err, ack, 1'b0};
    uio_oe = 8'b0000_0110;
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) if (lo == 4'(i)) rd_data = regs_flat[8*i +: 8];
  end
  // Datapath: response byte, sticky error and register file updated on each capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      uo_out <= '0;
      err <= 1'b0;
      wr_idx <= '0;
      regs_flat <= '0;
    end else if (cap) begin
      if (cmd_state == C_WDATA) begin
        for (int i = 0; i < NREGS; i++) if (wr_idx == 4'(i)) regs_flat[8*i +: 8] <= ui_in;
        uo_out <= ui_in;
      end else begin
        err <= !op_ok;
        uo_out <= !op_ok ? 8'hEE : is_rd ? rd_data : is_clr ? 8'h00 : ui_in;
        if (is_wr) wr_idx <= lo;
        if (is_clr) regs_flat <= '0;
      end
    end
endmodule

// File: tb/tb_pin_cmd_responder.sv
// tb_pin_cmd_responder: scoreboard bench for the strobe/ack command responder
module tb_pin_cmd_responder;
  logic clk = 0, rst = 1, ena = 1;
  logic [7:0] ui_in = 0, uio_in = 8'hAA, uo_out, uio_out, uio_oe;
  logic [63:0] regs_flat, exp_regs;
  logic ack, err, ack_q = 0;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [7:0] uo; logic err; logic [63:0] regs;} exp_t;
  exp_t sbq[$];
  assign ack = uio_out[1];
  assign err = uio_out[2];
  pin_cmd_responder dut (.clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .regs_flat(regs_flat));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask
  task automatic expect_rsp(input logic [7:0] uo, input logic e, input logic [63:0] r);
    exp_t x;
    x.uo = uo; x.err = e; x.regs = r;
    sbq.push_back(x);
  endtask
  task automatic strobe_up(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    ui_in = b;
    uio_in[0] = 1;
    while (n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ack) break;
    end
    chk("ack_rise_edges", n, 3);
  endtask
  task automatic strobe_down();
    int n = 0;
    uio_in[0] = 0;
    while (n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!ack) break;
    end
    chk("ack_fall_edges", n, 3);
  endtask
  task automatic send(input logic [7:0] b, input logic [7:0] uo, input logic e, input logic [63:0] r);
    expect_rsp(uo, e, r);
    strobe_up(b);
    strobe_down();
  endtask
  task automatic async_reset_check();
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("rst_uo_out", uo_out, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_uio_oe", uio_oe, 8'h06);
    @(negedge clk) rst = 0;
    @(negedge clk);
    chk("rst_regs", regs_flat, 0);
  endtask
  // Monitor: every ack rise is one capture; pop its expected response
  always @(negedge clk) begin
    exp_t e;
    if (ack && !ack_q) begin
      chk("sb_has_entry", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("uo_out", uo_out, e.uo);
        chk("err", err, e.err);
        chk("regs_flat", regs_flat, e.regs);
      end
    end
    ack_q = ack;
  end
  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t limit 200000", $time);
    $fatal(1);
  end
  initial begin
    logic seen;
    #1;
    chk("init_uo_out", uo_out, 0);
    chk("init_ack", ack, 0);
    chk("init_uio_oe", uio_oe, 8'h06);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("init_regs", regs_flat, 0);
    send(8'h13, 8'h13, 0, 64'h0);
    send(8'h5A, 8'h5A, 0, 64'h0000_0000_5A00_0000);
    send(8'h23, 8'h5A, 0, 64'h0000_0000_5A00_0000);
    send(8'h28, 8'hEE, 1, 64'h0000_0000_5A00_0000);
    send(8'h55, 8'hEE, 1, 64'h0000_0000_5A00_0000);
    send(8'h20, 8'h00, 0, 64'h0000_0000_5A00_0000);
    send(8'h10, 8'h10, 0, 64'h0000_0000_5A00_0000);
    send(8'hEE, 8'hEE, 0, 64'h0000_0000_5A00_00EE);
    send(8'h20, 8'hEE, 0, 64'h0000_0000_5A00_00EE);
    exp_regs = 64'h0000_0000_5A00_00EE;
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i), 8'h10 + 8'(i), 0, exp_regs);
      exp_regs[8*i +: 8] = 8'(i + 1);
      send(8'(i + 1), 8'(i + 1), 0, exp_regs);
    end
    chk("all_regs", regs_flat, 64'h0807_0605_0403_0201);
    send(8'h30, 8'h00, 0, 64'h0);
    send(8'h12, 8'h12, 0, 64'h0);
    @(negedge clk);
    ena = 0;
    ui_in = 8'h77;
    uio_in[0] = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack) seen = 1;
    end
    uio_in[0] = 0;
    repeat (5) @(negedge clk);
    chk("ena0_no_ack", seen, 0);
    chk("ena0_uo_hold", uo_out, 8'h12);
    ena = 1;
    send(8'h44, 8'h44, 0, 64'h0000_0000_0044_0000);
    expect_rsp(8'h44, 0, 64'h0000_0000_0044_0000);
    strobe_up(8'h22);
    ena = 0;
    strobe_down();
    ena = 1;
    expect_rsp(8'h14, 0, 64'h0000_0000_0044_0000);
    strobe_up(8'h14);
    repeat (20) @(negedge clk);
    strobe_down();
    send(8'h99, 8'h99, 0, 64'h0000_0099_0044_0000);
    send(8'h15, 8'h15, 0, 64'h0000_0099_0044_0000);
    async_reset_check();
    send(8'h21, 8'h00, 0, 64'h0);
    chk("reg5_after_rst", regs_flat[47:40], 0);
    repeat (5) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
